// File: rtl/rvdff_pipe_if.sv
// Handshake bundle for the elastic pipeline register: upstream push side,
// downstream pop side, flush and fill level.
interface rvdff_pipe_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/rvdff_pipe.sv
// Stallable, flushable delay line of DEPTH WIDTH-bit stages with per-stage
// valid bits and bubble collapse.
module rvdff_pipe #(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic         clk,
  input logic         rst,
  rvdff_pipe_if.slave bus
);
  localparam int               OCC_W   = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  logic [DEPTH-1:0] v_r;
  logic [WIDTH-1:0] d_r [DEPTH];
  logic [OCC_W-1:0] occ_r;
  logic [DEPTH-1:0] rdy_s;
  logic [DEPTH-1:0] vin_s;
  logic [WIDTH-1:0] din_s [DEPTH];
  logic             in_ready_s;
  logic             accept_s;
  logic             deliver_s;

  // Ready chain: a stage can load when it is empty or the stage ahead moves.
  always_comb begin
    logic rdy_chain_s;
    rdy_chain_s = bus.out_ready;
    rdy_s       = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy_chain_s = ~v_r[k] | rdy_chain_s;
      rdy_s[k]    = rdy_chain_s;
    end
  end

  // Per-stage incoming valid/data: stage 0 from upstream, others from the stage behind.
  always_comb begin
    vin_s    = '0;
    vin_s[0] = bus.in_valid;
    din_s[0] = bus.in_data;
    for (int k = 1; k < DEPTH; k++) begin
      vin_s[k] = v_r[k-1];
      din_s[k] = d_r[k-1];
    end
  end

  assign in_ready_s = rdy_s[0] & ~bus.flush;
  assign accept_s   = bus.in_valid & in_ready_s;
  assign deliver_s  = v_r[DEPTH-1] & bus.out_ready;

  // Stage registers; data only moves with a valid entry so bubbles never toggle d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_r[k] <= RST_VAL;
      end
    end else if (bus.flush) begin
      v_r <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy_s[k]) begin
          v_r[k] <= vin_s[k];
          if (vin_s[k]) begin
            d_r[k] <= din_s[k];
          end
        end
      end
    end
  end

  // Fill level tracked incrementally so it matches popcount(v_r) without an adder tree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_r <= '0;
    end else if (bus.flush) begin
      occ_r <= '0;
    end else begin
      case ({accept_s, deliver_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = v_r[DEPTH-1];
  assign bus.out_data  = d_r[DEPTH-1];
  assign bus.occupancy = occ_r;
endmodule

// File: tb/tb_rvdff_pipe.sv
// Self-checking bench for rvdff_pipe: directed vector table, async reset check,
// and randomized traffic against a queue-based reference model plus scoreboard.
module tb_rvdff_pipe;
  localparam int         WIDTH   = 8;
  localparam int         DEPTH   = 3;
  localparam logic [7:0] RST_VAL = 8'hA5;

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_rdy;
    logic       e_ov;
    logic [7:0] e_od;
    int         e_occ;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         pos;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  vec_t       tbl [$];
  ent_t       mq [$];
  logic [7:0] sb [$];

  rvdff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  rvdff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic fl, input logic iv, input logic [7:0] id,
                              input logic ordy, input logic rdy, input logic ov,
                              input logic [7:0] od, input int occ);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_rdy = rdy; v.e_ov = ov; v.e_od = od; v.e_occ = occ;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [7:0] id, input logic ordy);
    @(negedge clk);
    bus.flush     = fl;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    #1;
  endtask

  // Reference model: queue of entries oldest-first with their stage position.
  task automatic model_step(input logic fl, input logic iv, input logic [7:0] id, input logic ordy);
    int   lim;
    int   np;
    bit   del;
    bit   acc;
    ent_t e;
    if (fl) begin
      mq.delete();
    end else begin
      del = (mq.size() > 0) && (mq[0].pos == DEPTH - 1) && ordy;
      acc = iv && (ordy || mq.size() < DEPTH);
      if (del) void'(mq.pop_front());
      lim = DEPTH - 1;
      foreach (mq[i]) begin
        np        = (mq[i].pos + 1 < lim) ? mq[i].pos + 1 : lim;
        mq[i].pos = np;
        lim       = np - 1;
      end
      if (acc) begin
        e.data = id;
        e.pos  = 0;
        mq.push_back(e);
      end
    end
  endtask

  task automatic model_check();
    int m_rdy;
    int m_ov;
    m_rdy = (!bus.flush && (bus.out_ready || mq.size() < DEPTH)) ? 1 : 0;
    m_ov  = (mq.size() > 0 && mq[0].pos == DEPTH - 1) ? 1 : 0;
    check("rnd_in_ready", int'(bus.in_ready), m_rdy);
    check("rnd_out_valid", int'(bus.out_valid), m_ov);
    check("rnd_occupancy", int'(bus.occupancy), mq.size());
    if (m_ov == 1) check("rnd_out_data", int'(bus.out_data), int'(mq[0].data));
  endtask

  // Scoreboard on real handshakes, then advance the model across the edge.
  task automatic step();
    logic [7:0] exp_d;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("sb_spurious", 1, 0);
      end else begin
        exp_d = sb.pop_front();
        check("sb_order", int'(bus.out_data), int'(exp_d));
      end
    end
    if (bus.flush) sb.delete();
    if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
    model_step(bus.flush, bus.in_valid, bus.in_data, bus.out_ready);
    @(posedge clk);
  endtask

  initial begin
    vec_t v;
    logic fl, iv, ordy;
    logic [7:0] id;

    // Directed table: streaming, stall fill, bubble collapse, flush, full throughput.
    tbl.push_back(mk(1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'h00, 1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 8'h00, 2));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 3));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 2));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h00, 0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 8'h00, 2));
    tbl.push_back(mk(1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 8'h10, 3));
    tbl.push_back(mk(1'b0, 1'b1, 8'h13, 1'b1, 1'b1, 1'b1, 8'h10, 3));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 3));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 2));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h13, 1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 8'h00, 0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h21, 1'b0, 1'b1, 1'b0, 8'h00, 1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h20, 2));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h20, 3));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h20, 3));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h21, 2));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h30, 1'b0, 1'b1, 1'b0, 8'h00, 0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h31, 1'b0, 1'b1, 1'b0, 8'h00, 1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h32, 1'b0, 1'b1, 1'b0, 8'h00, 2));
    tbl.push_back(mk(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h30, 3));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 8'h00, 0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 8'h00, 1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h42, 1'b0, 1'b1, 1'b0, 8'h00, 2));
    tbl.push_back(mk(1'b0, 1'b1, 8'h43, 1'b1, 1'b1, 1'b1, 8'h40, 3));
    tbl.push_back(mk(1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h41, 3));
    tbl.push_back(mk(1'b0, 1'b1, 8'h45, 1'b1, 1'b1, 1'b1, 8'h42, 3));
    tbl.push_back(mk(1'b0, 1'b1, 8'h46, 1'b1, 1'b1, 1'b1, 8'h43, 3));
    tbl.push_back(mk(1'b0, 1'b1, 8'h47, 1'b1, 1'b1, 1'b1, 8'h44, 3));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h45, 3));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h46, 2));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h47, 1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0));

    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_out_valid", int'(bus.out_valid), 0);
    check("post_reset_out_data", int'(bus.out_data), int'(RST_VAL));
    check("post_reset_occupancy", int'(bus.occupancy), 0);
    check("post_reset_in_ready", int'(bus.in_ready), 1);

    // Fill, then assert reset mid-cycle and expect outputs to clear with no edge.
    repeat (3) begin
      drive(1'b0, 1'b1, 8'h77, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("prefill_out_valid", int'(bus.out_valid), 1);
    check("prefill_occupancy", int'(bus.occupancy), 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", int'(bus.out_valid), 0);
    check("async_rst_out_data", int'(bus.out_data), int'(RST_VAL));
    check("async_rst_occupancy", int'(bus.occupancy), 0);
    check("async_rst_in_ready", int'(bus.in_ready), 1);
    mq.delete();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.fl, v.iv, v.id, v.ordy);
      check($sformatf("vec%0d_in_ready", i), int'(bus.in_ready), int'(v.e_rdy));
      check($sformatf("vec%0d_out_valid", i), int'(bus.out_valid), int'(v.e_ov));
      check($sformatf("vec%0d_occupancy", i), int'(bus.occupancy), v.e_occ);
      if (v.e_ov) check($sformatf("vec%0d_out_data", i), int'(bus.out_data), int'(v.e_od));
      step();
    end

    // Random traffic: first half stall-heavy, second half mostly flowing.
    for (int i = 0; i < 600; i++) begin
      fl   = ($urandom_range(0, 24) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      id   = 8'($urandom);
      ordy = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      drive(fl, iv, id, ordy);
      model_check();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
